// File: rtl/id_exe_reg_pkg.sv
// id_exe_reg_pkg: shared field widths, ALU command encodings and squash helper for the ID/EXE stage
package id_exe_reg_pkg;
  localparam int EXE_CMD_W  = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int SIMM_W     = 24;
  localparam int REG_ID_W   = 4;
  localparam int STATUS_W   = 4;
  localparam int CTRL_W     = 6;
  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NOP = 4'h0,
    EXE_MOV = 4'h1,
    EXE_ADD = 4'h2,
    EXE_ADC = 4'h3,
    EXE_SUB = 4'h4,
    EXE_SBC = 4'h5,
    EXE_AND = 4'h6,
    EXE_ORR = 4'h7,
    EXE_EOR = 4'h8,
    EXE_MVN = 4'h9
  } exe_cmd_e;
  // CMP/TST and LDR/STR reuse the ALU ops that compute their result
  localparam logic [EXE_CMD_W-1:0] EXE_CMP = EXE_SUB;
  localparam logic [EXE_CMD_W-1:0] EXE_TST = EXE_AND;
  localparam logic [EXE_CMD_W-1:0] EXE_LDR = EXE_ADD;
  localparam logic [EXE_CMD_W-1:0] EXE_STR = EXE_ADD;
  // a failed condition turns the instruction into a bubble: no side effects, not valid
  function automatic logic [CTRL_W-1:0] squash(input logic pass, input logic [CTRL_W-1:0] c);
    return pass ? c : '0;
  endfunction
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline register with async reset, sync clear (priority) and enable
// ports: clk, rst (async, active-high), clr_i (sync clear), en_i (load enable), d_i, q_o
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (en_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with flush (bubble), freeze (stall) and condition squash
// ports: clk, rst (async); freeze, flush, cond_pass; ID fields *_in; registered copies *_out;
//        valid_out marks a live instruction. Priority per edge: rst > flush > freeze > load.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  cond_pass,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [SHIFT_OP_W-1:0] shift_op_in,
  input  logic                  imm_in,
  input  logic [SIMM_W-1:0]     simm24_in,
  input  logic [REG_ID_W-1:0]   dest_in,
  input  logic [REG_ID_W-1:0]   src1_in,
  input  logic [REG_ID_W-1:0]   src2_in,
  input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [STATUS_W-1:0]   status_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [SHIFT_OP_W-1:0] shift_op_out,
  output logic                  imm_out,
  output logic [SIMM_W-1:0]     simm24_out,
  output logic [REG_ID_W-1:0]   dest_out,
  output logic [REG_ID_W-1:0]   src1_out,
  output logic [REG_ID_W-1:0]   src2_out,
  output logic [EXE_CMD_W-1:0]  exe_cmd_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  wb_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [STATUS_W-1:0]   status_out,
  output logic                  valid_out
);
  localparam int DW = 3 * DATA_W + SHIFT_OP_W + 1 + SIMM_W + 3 * REG_ID_W + EXE_CMD_W;
  logic [DW-1:0]       data_d, data_q;
  logic [CTRL_W-1:0]   ctrl_d, ctrl_q;
  logic [STATUS_W-1:0] status_q;
  logic                load;
  assign load   = ~freeze;
  // data fields (incl. source ids for forwarding) are kept even when the condition fails
  assign data_d = {pc_in, val_rn_in, val_rm_in, shift_op_in, imm_in, simm24_in,
                   dest_in, src1_in, src2_in, exe_cmd_in};
  assign ctrl_d = squash(cond_pass, {mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, 1'b1});
  pipe_field_reg #(.W(DW)) u_data (
    .clk(clk), .rst(rst), .clr_i(flush), .en_i(load), .d_i(data_d), .q_o(data_q)
  );
  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .clr_i(flush), .en_i(load), .d_i(ctrl_d), .q_o(ctrl_q)
  );
  pipe_field_reg #(.W(STATUS_W)) u_status (
    .clk(clk), .rst(rst), .clr_i(flush), .en_i(load), .d_i(status_in), .q_o(status_q)
  );
  assign {pc_out, val_rn_out, val_rm_out, shift_op_out, imm_out, simm24_out,
          dest_out, src1_out, src2_out, exe_cmd_out} = data_q;
  assign {mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, valid_out} = ctrl_q;
  assign status_out = status_q;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed and random checks of the ID/EXE pipeline register
module tb_id_exe_reg;
  logic        clk = 0, rst = 1, freeze = 0, flush = 0, cond_pass = 0;
  logic [31:0] pc_in = 0, val_rn_in = 0, val_rm_in = 0;
  logic [11:0] shift_op_in = 0;
  logic        imm_in = 0;
  logic [23:0] simm24_in = 0;
  logic [3:0]  dest_in = 0, src1_in = 0, src2_in = 0, exe_cmd_in = 0, status_in = 0;
  logic        mem_r_en_in = 0, mem_w_en_in = 0, wb_en_in = 0, b_in = 0, s_in = 0;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_op_out;
  logic        imm_out;
  logic [23:0] simm24_out;
  logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, status_out;
  logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, valid_out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_exe_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .cond_pass(cond_pass),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_op_in(shift_op_in),
    .imm_in(imm_in), .simm24_in(simm24_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .status_in(status_in), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_op_out(shift_op_out), .imm_out(imm_out), .simm24_out(simm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
    .b_out(b_out), .s_out(s_out), .status_out(status_out), .valid_out(valid_out)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [31:0] m_pc;
  logic [3:0]  m_cmd, m_src1, m_st;
  logic        m_wb, m_b, m_valid;
  initial begin
    #1;
    chk("rst_pc", pc_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_status", status_out, 0);
    @(negedge clk) rst = 0;
    cond_pass = 1; pc_in = 32'h10; wb_en_in = 1; dest_in = 4'h3;
    step();
    chk("load_pc", pc_out, 32'h10);
    chk("load_wb", wb_en_out, 1);
    chk("load_dest", dest_out, 3);
    chk("load_valid", valid_out, 1);
    cond_pass = 0; mem_w_en_in = 1; val_rm_in = 32'hDEAD_BEEF; src1_in = 4'h5;
    step();
    chk("nc_memw", mem_w_en_out, 0);
    chk("nc_wb", wb_en_out, 0);
    chk("nc_valrm", val_rm_out, 32'hDEAD_BEEF);
    chk("nc_src1", src1_out, 5);
    chk("nc_valid", valid_out, 0);
    cond_pass = 1; mem_w_en_in = 0; exe_cmd_in = 4'h2;
    step();
    chk("frz_load", exe_cmd_out, 2);
    freeze = 1; exe_cmd_in = 4'h9; pc_in = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold_cmd", exe_cmd_out, 2);
      chk("frz_hold_valid", valid_out, 1);
    end
    freeze = 0;
    step();
    chk("frz_release", exe_cmd_out, 9);
    chk("frz_release_pc", pc_out, 32'h44);
    flush = 1; freeze = 1; b_in = 1; status_in = 4'hA;
    step();
    chk("fl_pc", pc_out, 0);
    chk("fl_b", b_out, 0);
    chk("fl_wb", wb_en_out, 0);
    chk("fl_cmd", exe_cmd_out, 0);
    chk("fl_status", status_out, 0);
    chk("fl_valid", valid_out, 0);
    flush = 0; freeze = 0; b_in = 0; status_in = 4'hF; pc_in = 32'h1234;
    step();
    chk("ar_pre_status", status_out, 4'hF);
    #2 rst = 1;
    #1;
    chk("ar_pc", pc_out, 0);
    chk("ar_status", status_out, 0);
    chk("ar_valid", valid_out, 0);
    rst = 0;
    step();
    chk("ar_reload_pc", pc_out, 32'h1234);
    freeze = 1;
    step();
    #2 rst = 1;
    #1 rst = 0;
    step();
    chk("rf_pc", pc_out, 0);
    chk("rf_valid", valid_out, 0);
    m_pc = 0; m_cmd = 0; m_src1 = 0; m_st = 0; m_wb = 0; m_b = 0; m_valid = 0;
    for (int n = 0; n < 10000; n++) begin
      freeze = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cond_pass = $urandom_range(0, 1);
      pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      shift_op_in = 12'($urandom); imm_in = 1'($urandom); simm24_in = 24'($urandom);
      dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
      exe_cmd_in = 4'($urandom); status_in = 4'($urandom);
      mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom); wb_en_in = 1'($urandom);
      b_in = 1'($urandom); s_in = 1'($urandom);
      if (flush) begin
        m_pc = 0; m_cmd = 0; m_src1 = 0; m_st = 0; m_wb = 0; m_b = 0; m_valid = 0;
      end else if (!freeze) begin
        m_pc = pc_in; m_cmd = exe_cmd_in; m_src1 = src1_in; m_st = status_in;
        m_wb = cond_pass & wb_en_in; m_b = cond_pass & b_in; m_valid = cond_pass;
      end
      step();
      chk("inv_ctrl", {mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out} & {5{~valid_out}}, 0);
      chk("rnd_state", {m_pc, m_cmd, m_src1, m_st, m_wb, m_b, m_valid},
          {pc_out, exe_cmd_out, src1_out, status_out, wb_en_out, b_out, valid_out});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
